// File: rtl/medidor_pulsos.sv
// Pulse-width meter for the three RGB timer flags: measures each flag's total
// high time per frame (in ticks of TICK_DIV cycles) and reports it with a strobe.
module medidor_pulsos #(
  parameter int TICK_DIV = 1,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flag_R,
  input  logic          flag_G,
  input  logic          flag_B,
  output logic [CW-1:0] meas_R,
  output logic [CW-1:0] meas_G,
  output logic [CW-1:0] meas_B,
  output logic [2:0]    ovf,
  output logic          valid,
  output logic          busy
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_START = PW'(1 % TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [CW-1:0] meas_q [3];
  logic [CW-1:0] meas_d [3];
  logic [2:0]    ovfAcc_q, ovfAcc_d;
  logic [2:0]    ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

  logic [2:0] flags;
  logic       tick;

  assign flags = {flag_B, flag_G, flag_R};
  assign tick  = (pre_q == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      ovfAcc_q <= '0;
      ovf_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]  <= '0;
        meas_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      ovfAcc_q <= ovfAcc_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]  <= cnt_d[i];
        meas_q[i] <= meas_d[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    ovfAcc_d = ovfAcc_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]  = cnt_q[i];
      meas_d[i] = meas_q[i];
    end

    case (state_q)
      IDLE: begin
        pre_d = '0;
        // The start edge already counts as the first cycle of each active pulse.
        if (|flags) begin
          state_d  = MEAS;
          busy_d   = 1'b1;
          pre_d    = PRE_START;
          ovfAcc_d = '0;
          for (int i = 0; i < 3; i++) begin
            cnt_d[i] = (flags[i] && tick) ? CNT_ONE : '0;
          end
        end
      end

      MEAS: begin
        if (flags == 3'b000) begin
          state_d = IDLE;
          pre_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          ovf_d   = ovfAcc_q;
          for (int i = 0; i < 3; i++) begin
            meas_d[i] = cnt_q[i];
          end
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          // Saturate at the maximum and flag the lost increment instead.
          for (int i = 0; i < 3; i++) begin
            if (flags[i] && tick) begin
              if (cnt_q[i] == CNT_MAX) begin
                ovfAcc_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign meas_R = meas_q[0];
  assign meas_G = meas_q[1];
  assign meas_B = meas_q[2];
  assign ovf    = ovf_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule
